// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling ratio and parity helper,
// common to the transmitter and the oversampling receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // XOR of the low `width` bits of `data`, inverted for odd parity.
  function automatic logic parity_of(input logic [7:0]  data,
                                     input int unsigned width,
                                     input logic        odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
// Paced by a 16x-baud s_tick enable; tx_out is driven straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  s_tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx_busy,
  output logic                  tx_done_tick,
  output logic                  tx_out
);

  localparam int unsigned SMax = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int unsigned SW   = $clog2(SMax);
  localparam int unsigned NW   = $clog2(DATA_WIDTH);

  localparam logic [SW-1:0] SBitLast  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SStopLast = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast     = NW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  done;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          state_d = StStart;
          s_d     = '0;
          b_d     = tx_data_in;
          // Parity is taken at accept since the shift register is consumed during DATA.
          par_d   = parity_of(8'(tx_data_in), DATA_WIDTH, PARITY_ODD != 0);
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SBitLast) begin
            s_d     = '0;
            n_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SBitLast) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NLast) begin
              state_d = (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == SBitLast) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SStopLast) begin
            s_d     = '0;
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so the pin changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = b_d[0];
      StParity: tx_d = par_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_out       = tx_q;
  assign tx_busy      = (state_q != StIdle);
  assign tx_done_tick = done;

endmodule
